// File: rtl/rom_wave_pkg.sv
// Shared constants for the waveform ROM readers: default widths, the
// dither LFSR polynomial/seed and the sample-buffer sizing rule.
package rom_wave_pkg;

    localparam int ACC_WIDTH_DEF  = 32;
    localparam int ADDR_WIDTH_DEF = 10;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ROM_LAT_DEF    = 1;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Buffer must hold every read that can be in flight plus one extra
    // slot so the issue pipeline never has to stall in steady state.
    function automatic int fifo_depth(input int latency);
        return latency + 2;
    endfunction

endpackage

// File: rtl/rom_wave_sample_fifo.sv
// First-word-fall-through sample buffer with a registered head.
// sample/sample_valid come straight from flops; the head is refilled on
// the same edge as a pop (from storage, or from the incoming word when
// the buffer would otherwise run dry).
module rom_wave_sample_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CNT_W-1:0] cnt_after_pop, cnt_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok = pop & sample_valid;

    // Next occupancy and next head word
    always_comb begin
        rd_nxt        = pop_ok ? ptr_inc(rd_ptr) : rd_ptr;
        cnt_after_pop = count - CNT_W'(pop_ok);
        cnt_nxt       = cnt_after_pop + CNT_W'(push);
        head_nxt      = (cnt_after_pop == '0) ? push_data : mem[rd_nxt];
    end

    // Storage array, no reset needed: occupancy gates every read
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    // Pointers, count and the registered head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            rd_ptr       <= rd_nxt;
            count        <= cnt_nxt;
            sample_valid <= (cnt_nxt != '0);
            if (cnt_nxt != '0)
                sample <= head_nxt;
        end
    end

endmodule

// File: rtl/rom_wave_reader.sv
// DDS read initiator for the waveform ROMs. A phase accumulator produces
// table addresses, a flag shift register tracks reads in flight through
// the ROM, and returned words land in a small FWFT buffer exposed with
// valid/ready. Reads are only issued when a buffer slot is guaranteed,
// so backpressure can never drop a sample.
// Optional build macro: ROM_WAVE_READER_PHASE_DITHER_EN adds LFSR phase
// dither to the address path (stored accumulator is never dithered).
module rom_wave_reader
    import rom_wave_pkg::*;
#(
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ROM_LATENCY = ROM_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  cfg_load,
    input  logic [ACC_WIDTH-1:0]  freq_word,
    input  logic [ADDR_WIDTH-1:0] phase_off,
    input  logic                  phase_clr,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic [DATA_WIDTH-1:0] sample,
    output logic                  sample_valid,
    input  logic                  sample_ready
);

    localparam int FIFO_DEPTH = fifo_depth(ROM_LATENCY);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int FRAC_W     = ACC_WIDTH - ADDR_WIDTH;

    logic [ACC_WIDTH-1:0]  acc, freq_shadow, acc_addr;
    logic [ADDR_WIDTH-1:0] phase_shadow;
    logic [ROM_LATENCY:0]  vld_pipe;
    logic [CNT_W-1:0]      count, inflight;
    logic                  issue, push, pop;

    // Reads currently travelling through the ROM
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= ROM_LATENCY; i++)
            inflight = inflight + CNT_W'(vld_pipe[i]);
    end

    assign push = vld_pipe[ROM_LATENCY];
    assign pop  = sample_valid & sample_ready;

    // Credit check: buffered + in-flight must leave room for this read.
    // A slot being popped on this same edge already counts as free, which
    // is what lets a continuously-ready consumer get one sample per clock.
    assign issue = en & ~phase_clr &
                   (((CNT_W+1)'(count) + (CNT_W+1)'(inflight)) <
                    ((CNT_W+1)'(FIFO_DEPTH) + (CNT_W+1)'(pop)));

`ifdef ROM_WAVE_READER_PHASE_DITHER_EN
    localparam int DITH_W = (FRAC_W < 16) ? FRAC_W : 16;

    logic [15:0] lfsr;

    // Dither source, stepped once per issued read
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else if (issue)
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    // Dither bits sit at the top of the fraction field, just below the address
    assign acc_addr = acc + (ACC_WIDTH'(lfsr[DITH_W-1:0]) << (FRAC_W - DITH_W));
`else
    assign acc_addr = acc;
`endif

    // Shadow config, phase accumulator, address register and in-flight flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= '0;
            freq_shadow  <= '0;
            phase_shadow <= '0;
            rom_addr     <= '0;
            vld_pipe     <= '0;
        end else begin
            if (cfg_load) begin
                freq_shadow  <= freq_word;
                phase_shadow <= phase_off;
            end
            if (phase_clr)
                acc <= '0;
            else if (issue)
                acc <= acc + freq_shadow;
            if (issue)
                rom_addr <= acc_addr[ACC_WIDTH-1 -: ADDR_WIDTH] + phase_shadow;
            vld_pipe <= {vld_pipe[ROM_LATENCY-1:0], issue};
        end
    end

    rom_wave_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_data    (rom_rd_data),
        .pop          (pop),
        .sample       (sample),
        .sample_valid (sample_valid),
        .count        (count)
    );

endmodule
